// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and divider constants for the mdu_hilo multiply/divide unit.
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_DIV   = 4'd2,
      OP_DIVU  = 4'd3,
      OP_MTHI  = 4'd4,
      OP_MTLO  = 4'd5,
      OP_MADD  = 4'd6,
      OP_MADDU = 4'd7,
      OP_MSUB  = 4'd8,
      OP_MSUBU = 4'd9
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   localparam int DIV_ITERS = 32;

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned 32-cycle restoring divider: load latches operands, each step retires one quotient bit.
module mdu_div_core (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic        i_step,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic [31:0] o_quot,
   output logic [31:0] o_rem
);

   logic [31:0] r_rem;
   logic [31:0] r_quot;
   logic [31:0] r_divisor;
   logic [32:0] w_shift;
   logic [32:0] w_diff;

   // The partial remainder stays below the divisor, so the shifted value fits in 33 bits.
   assign w_shift = {r_rem, r_quot[31]};
   assign w_diff  = w_shift - {1'b0, r_divisor};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rem     <= '0;
         r_quot    <= '0;
         r_divisor <= '0;
      end else if (i_load) begin
         r_rem     <= '0;
         r_quot    <= i_dividend;
         r_divisor <= i_divisor;
      end else if (i_step) begin
         if (!w_diff[32]) begin
            r_rem  <= w_diff[31:0];
            r_quot <= {r_quot[30:0], 1'b1};
         end else begin
            r_rem  <= w_shift[31:0];
            r_quot <= {r_quot[30:0], 1'b0};
         end
      end
   end

   assign o_quot = r_quot;
   assign o_rem  = r_rem;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to add the madd/maddu/msub/msubu accumulate ops.
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_t      r_state;
   logic        r_busy;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [5:0]  r_count;
   logic [63:0] r_acc;
   logic        r_negQ;
   logic        r_negR;
   logic        r_divZero;
   logic [31:0] r_aSave;

   logic        w_isMul, w_isDiv, w_signed, w_accAdd, w_accSub, w_mthi, w_mtlo;
   logic        w_accept;
   logic [63:0] w_aExt, w_bExt, w_prod, w_mulResult;
   logic [31:0] w_aMag, w_bMag, w_quot, w_rem;

   always_comb begin
      w_isMul  = 1'b0;
      w_isDiv  = 1'b0;
      w_signed = 1'b0;
      w_accAdd = 1'b0;
      w_accSub = 1'b0;
      w_mthi   = 1'b0;
      w_mtlo   = 1'b0;
      case (op)
         OP_MULT:  begin w_isMul = 1'b1; w_signed = 1'b1; end
         OP_MULTU: w_isMul = 1'b1;
         OP_DIV:   begin w_isDiv = 1'b1; w_signed = 1'b1; end
         OP_DIVU:  w_isDiv = 1'b1;
         OP_MTHI:  w_mthi = 1'b1;
         OP_MTLO:  w_mtlo = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD:  begin w_isMul = 1'b1; w_signed = 1'b1; w_accAdd = 1'b1; end
         OP_MADDU: begin w_isMul = 1'b1; w_accAdd = 1'b1; end
         OP_MSUB:  begin w_isMul = 1'b1; w_signed = 1'b1; w_accSub = 1'b1; end
         OP_MSUBU: begin w_isMul = 1'b1; w_accSub = 1'b1; end
`endif
         default: ;
      endcase
   end

   assign w_accept = start & ~r_busy;

   // The full product and any accumulate are formed at issue; MUL only models latency.
   assign w_aExt      = w_signed ? {{32{a[31]}}, a} : {32'b0, a};
   assign w_bExt      = w_signed ? {{32{b[31]}}, b} : {32'b0, b};
   assign w_prod      = w_aExt * w_bExt;
   assign w_mulResult = w_accAdd ? ({r_hi, r_lo} + w_prod) :
                        w_accSub ? ({r_hi, r_lo} - w_prod) : w_prod;

   assign w_aMag = (w_signed && a[31]) ? (~a + 32'd1) : a;
   assign w_bMag = (w_signed && b[31]) ? (~b + 32'd1) : b;

   mdu_div_core u_divCore (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept & w_isDiv),
      .i_step     (r_state == ST_DIV),
      .i_dividend (w_aMag),
      .i_divisor  (w_bMag),
      .o_quot     (w_quot),
      .o_rem      (w_rem)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_busy    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_count   <= '0;
         r_acc     <= '0;
         r_negQ    <= 1'b0;
         r_negR    <= 1'b0;
         r_divZero <= 1'b0;
         r_aSave   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_isMul) begin
                     r_acc   <= w_mulResult;
                     r_count <= 6'(MULT_CYCLES - 1);
                     r_busy  <= 1'b1;
                     r_state <= ST_MUL;
                  end else if (w_isDiv) begin
                     r_negQ    <= w_signed & (a[31] ^ b[31]);
                     r_negR    <= w_signed & a[31];
                     r_divZero <= (b == 32'd0);
                     r_aSave   <= a;
                     r_count   <= 6'(DIV_ITERS - 1);
                     r_busy    <= 1'b1;
                     r_state   <= ST_DIV;
                  end else if (w_mthi) begin
                     r_hi <= a;
                  end else if (w_mtlo) begin
                     r_lo <= a;
                  end
               end
            end
            ST_MUL: begin
               if (r_count == 6'd0) begin
                  {r_hi, r_lo} <= r_acc;
                  r_busy       <= 1'b0;
                  r_state      <= ST_IDLE;
               end else begin
                  r_count <= r_count - 6'd1;
               end
            end
            ST_DIV: begin
               if (r_count == 6'd0) begin
                  r_state <= ST_FIX;
               end else begin
                  r_count <= r_count - 6'd1;
               end
            end
            ST_FIX: begin
               // Divide by zero reports all-ones quotient and the original dividend.
               if (r_divZero) begin
                  r_lo <= 32'hFFFF_FFFF;
                  r_hi <= r_aSave;
               end else begin
                  r_lo <= r_negQ ? (~w_quot + 32'd1) : w_quot;
                  r_hi <= r_negR ? (~w_rem + 32'd1) : w_rem;
               end
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
